// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Ports: clock, clear (sync reset), run, mem_ready, ir in; datapath
// enables, encoded register selects, operation, halted, illegal,
// bus_error and state_dbg out. Mul/div opcodes need ALU_SEQ_MULDIV_EN.
module alu_op_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter logic [4:0]  HALT_OP    = 5'b11010
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        PCin,
  output logic        read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        LOin,
  output logic        HIin,
  output logic        Rout_en,
  output logic [3:0]  Rout_sel,
  output logic        Rin_en,
  output logic [3:0]  Rin_sel,
  output logic [4:0]  operation,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    C_RTYPE,
    C_HALT,
    C_MULDIV,
    C_ILLEGAL
  } op_cls_t;

  localparam int unsigned CW =
    (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic [4:0]    op_q, op_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_cls_t    cls;
  state_t     after_st;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  // Where a finished (or rejected) instruction goes next.
  assign after_st  = run ? S_T0 : S_IDLE;

  always_comb begin
    cls = C_ILLEGAL;
    if (opcode == HALT_OP)
      cls = C_HALT;
    else if (opcode <= 5'b01100)
      cls = C_RTYPE;
`ifdef ALU_SEQ_MULDIV_EN
    else if (opcode == 5'b01111 ||
             opcode == 5'b10000)
      cls = C_MULDIV;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    op_d    = op_q;
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      berr_d  = 1'b0;
      op_d    = 5'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (run) state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1: begin
          if (mem_ready) begin
            state_d = S_T2;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            // This was the last allowed wait cycle.
            state_d = S_HALT;
            berr_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_T2: state_d = S_T3;
        S_T3: begin
          unique case (cls)
            C_RTYPE,
            C_MULDIV: state_d = S_T4;
            C_HALT:   state_d = S_HALT;
            default:  state_d = after_st;
          endcase
        end
        S_T4: begin
          state_d = S_T5;
          op_d    = opcode;
        end
        S_T5: begin
          if (cls == C_MULDIV)
            state_d = S_T6;
          else
            state_d = after_st;
        end
`ifdef ALU_SEQ_MULDIV_EN
        S_T6: state_d = after_st;
`endif
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    berr_q  <= berr_d;
    op_q    <= op_d;
  end

  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    ZLOout    = 1'b0;
    ZHIout    = 1'b0;
    PCin      = 1'b0;
    read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    Rout_en   = 1'b0;
    Rout_sel  = 4'd0;
    Rin_en    = 1'b0;
    Rin_sel   = 4'd0;
    operation = op_q;
    illegal   = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        ZLOout = 1'b1;
        read   = 1'b1;
        // PC+1 is captured only on the first wait cycle.
        PCin   = (cnt_q == '0);
        MDRin  = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls == C_RTYPE ||
            cls == C_MULDIV) begin
          Rout_en  = 1'b1;
          Rout_sel = rb;
          Yin      = 1'b1;
        end
        illegal = (cls == C_ILLEGAL);
      end
      S_T4: begin
        Rout_en   = 1'b1;
        Rout_sel  = rc;
        Zlowin    = 1'b1;
        operation = opcode;
`ifdef ALU_SEQ_MULDIV_EN
        Zhighin   = (cls == C_MULDIV);
`endif
      end
      S_T5: begin
        ZLOout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (cls == C_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Rin_en  = 1'b1;
          Rin_sel = ra;
        end
`else
        Rin_en  = 1'b1;
        Rin_sel = ra;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign halted    = (state_q == S_HALT);
  assign bus_error = berr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural model compared every cycle,
// directed scenarios with literal expectations, then random stimulus.
module tb_alu_op_sequencer;

  localparam int         WL  = 15;
  localparam logic [4:0] HOP = 5'b11010;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zlowin, Zhighin, ZLOout, ZHIout;
  logic PCin, read, MDRin, MDRout, IRin, Yin, LOin, HIin;
  logic       Rout_en, Rin_en, halted, illegal, bus_error;
  logic [3:0] Rout_sel, Rin_sel, state_dbg;
  logic [4:0] operation;

  alu_op_sequencer #(.WAIT_LIMIT(WL), .HALT_OP(HOP)) dut (
    .clock(clock), .clear(clear), .run(run),
    .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .ZLOout(ZLOout),
    .ZHIout(ZHIout), .PCin(PCin), .read(read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .LOin(LOin), .HIin(HIin),
    .Rout_en(Rout_en), .Rout_sel(Rout_sel),
    .Rin_en(Rin_en), .Rin_sel(Rin_sel),
    .operation(operation), .halted(halted),
    .illegal(illegal), .bus_error(bus_error),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: step of the instruction, wait cycles spent, sticky error,
  // last executed operation.
  int          m_ph   = 0;
  int          m_wait = 0;
  bit          m_err  = 1'b0;
  logic [4:0]  m_op   = 5'd0;
  logic [31:0] next_ir;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 0 R-type, 1 halt, 2 mul/div, 3 undefined
  function automatic int cls(input logic [4:0] op);
    if (op == HOP) return 1;
    if (op <= 5'd12) return 0;
    if (MD && (op == 5'd15 || op == 5'd16)) return 2;
    return 3;
  endfunction

  // Enable vector order (bit 14 down to 0):
  // PCout MARin IncPC Zlowin Zhighin ZLOout ZHIout PCin read
  // MDRin MDRout IRin Yin LOin HIin
  function automatic logic [36:0] actv();
    return {state_dbg, halted, illegal, bus_error, operation,
            Rout_en, Rout_en ? Rout_sel : 4'd0,
            Rin_en, Rin_en ? Rin_sel : 4'd0,
            PCout, MARin, IncPC, Zlowin, Zhighin, ZLOout, ZHIout,
            PCin, read, MDRin, MDRout, IRin, Yin, LOin, HIin};
  endfunction

  function automatic logic [36:0] expv();
    logic [14:0] en;
    logic [4:0]  op, opx;
    logic [3:0]  rsel, risel;
    logic        rout, rin, ill, hlt;
    int          c;
    en = '0; rout = 0; rin = 0; ill = 0; hlt = 0;
    rsel = 0; risel = 0;
    op = ir[31:27];
    opx = m_op;
    c = cls(op);
    case (m_ph)
      1: en[14:11] = 4'b1111;
      2: begin
        en[9] = 1'b1;
        en[7] = (m_wait == 0);
        en[6] = 1'b1;
        en[5] = mem_ready;
      end
      3: en[4:3] = 2'b11;
      4: begin
        if (c == 0 || c == 2) begin
          rout = 1; rsel = ir[22:19]; en[2] = 1'b1;
        end
        ill = (c == 3);
      end
      5: begin
        rout = 1; rsel = ir[18:15];
        en[11] = 1'b1; en[10] = (c == 2); opx = op;
      end
      6: begin
        en[9] = 1'b1;
        if (c == 2) en[1] = 1'b1;
        else begin rin = 1; risel = ir[26:23]; end
      end
      7: begin en[8] = 1'b1; en[0] = 1'b1; end
      8: hlt = 1;
      default: ;
    endcase
    return {4'(m_ph), hlt, ill, m_err, opx, rout, rsel,
            rin, risel, en};
  endfunction

  function automatic void model_step();
    int c;
    c = cls(ir[31:27]);
    if (clear) begin
      m_ph = 0; m_wait = 0; m_err = 0; m_op = 0;
      return;
    end
    case (m_ph)
      0: if (run) m_ph = 1;
      1: m_ph = 2;
      2: begin
        if (mem_ready) begin
          m_ph = 3; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == WL) begin
            m_err = 1; m_ph = 8; m_wait = 0;
          end
        end
      end
      3: m_ph = 4;
      4: m_ph = (c == 1) ? 8 : (c == 3) ? (run ? 1 : 0) : 5;
      5: begin m_op = ir[31:27]; m_ph = 6; end
      6: m_ph = (c == 2) ? 7 : (run ? 1 : 0);
      7: m_ph = run ? 1 : 0;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(negedge clock);
    chk("cycle", 64'(actv()), 64'(expv()));
  endtask

  task automatic adv();
    bit load;
    load = (m_ph == 3) && !clear;
    @(posedge clock);
    model_step();
    #1;
    if (load) ir = next_ir;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      adv();
    end
  endtask

  int stuck = 0;
  logic [4:0] ro;

  initial begin
    clear = 1; run = 0; mem_ready = 0;
    ir = 32'h0; next_ir = 32'h0;
    adv();
    tick();
    chk("reset_state", state_dbg, 4'd0);
    chk("reset_op", operation, 5'd0);
    chk("reset_berr", bus_error, 1'b0);

    // R-type: R6 <= R6 op R4, opcode 01010
    clear = 0; run = 1; mem_ready = 1;
    ir = 32'h5332_0000; next_ir = 32'h5332_0000;
    adv();
    tick(); chk("rt_t0", state_dbg, 4'd1); adv();
    tick(); chk("rt_t1_pcin", PCin, 1'b1);
    chk("rt_t1_mdrin", MDRin, 1'b1); adv();
    tick(); chk("rt_t2", state_dbg, 4'd3); adv();
    tick(); chk("rt_t3_sel", {Rout_en, Rout_sel, Yin}, 6'b1_0110_1);
    adv();
    tick(); chk("rt_t4_sel", {Rout_en, Rout_sel}, 5'b1_0100);
    chk("rt_t4_op", operation, 5'b01010);
    chk("rt_t4_z", Zlowin, 1'b1); adv();
    tick(); chk("rt_t5", {Rin_en, Rin_sel, ZLOout}, 6'b1_0110_1);
    adv();
    tick(); chk("rt_back_t0", state_dbg, 4'd1);

    // Three wait cycles in T1; the loaded instruction is undefined.
    mem_ready = 0; next_ir = {5'b11111, 27'h0};
    adv();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      tick();
      chk("wt_state", state_dbg, 4'd2);
      chk("wt_pcin", PCin, i == 0);
      chk("wt_mdrin", MDRin, i == 3);
      chk("wt_berr", bus_error, 1'b0);
      adv();
    end
    tick(); adv();
    tick();
    chk("il_pulse", illegal, 1'b1);
    chk("il_noen", {Rout_en, Rin_en, Yin, Zlowin}, 4'b0);
    adv();
    tick();
    chk("il_after", {illegal, state_dbg}, 5'b0_0001);

    // Memory timeout
    mem_ready = 0;
    adv();
    for (int i = 0; i < WL; i++) begin
      tick();
      chk("to_wait", state_dbg, 4'd2);
      adv();
    end
    tick();
    chk("to_halt", {state_dbg, halted, bus_error}, 6'b1000_1_1);
    adv();
    tick();
    chk("to_stays", {halted, bus_error}, 2'b11);
    clear = 1; adv(); clear = 0;
    tick();
    chk("to_clear", {state_dbg, bus_error}, 5'b0);

    // Clear in the middle of T4
    mem_ready = 1; next_ir = 32'h5332_0000;
    adv();
    cycles(4);
    tick(); chk("cl_t4", state_dbg, 4'd5);
    clear = 1; adv(); clear = 0;
    tick();
    chk("cl_state", state_dbg, 4'd0);
    chk("cl_op", operation, 5'd0);
    chk("cl_en", {PCout, Zlowin, Rout_en, Yin, ZLOout}, 5'b0);
    adv();
    tick(); chk("cl_restart", state_dbg, 4'd1);

    // Multiply opcode
    next_ir = {5'b01111, 4'd3, 4'd5, 4'd7, 15'h0};
    adv();
    cycles(2);
    tick();
    if (MD) begin
      chk("md_t3", {illegal, Yin, Rout_sel}, 6'b0_1_0101);
      adv(); tick();
      chk("md_t4", {Zlowin, Zhighin, Rout_sel}, 6'b1_1_0111);
      adv(); tick();
      chk("md_t5", {ZLOout, LOin, Rin_en}, 3'b110);
      adv(); tick();
      chk("md_t6", {state_dbg, ZHIout, HIin}, 6'b0111_1_1);
    end else begin
      chk("md_illegal", {illegal, Yin}, 2'b10);
    end
    adv();
    tick(); chk("md_end", state_dbg, 4'd1);
    adv();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      clear = ($urandom_range(0, 59) == 0);
      run = ($urandom_range(0, 9) != 0);
      if (stuck > 0) begin
        mem_ready = 0;
        stuck--;
      end else begin
        if ($urandom_range(0, 149) == 0) stuck = 18;
        mem_ready = ($urandom_range(0, 2) != 0);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ro = 5'($urandom_range(0, 12));
        4:          ro = HOP;
        5:          ro = 5'b01111;
        6:          ro = 5'b10000;
        default:    ro = 5'($urandom_range(0, 31));
      endcase
      next_ir = {ro, 27'($urandom)};
      tick();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardwired control FSM for the single-bus datapath (bus, Y, Z, MAR/MDR, PC, R0-R15).
- Fetches an instruction, decodes the 5-bit opcode, and runs register-register ALU instructions in the T0-T5(T6) step style.
- Drives the datapath enables directly; register selection is encoded (select plus enable) for decode inside the register file.
- Owns memory read handshaking and halting.

Parameters:
- WAIT_LIMIT, 15: maximum cycles T1 waits for mem_ready before bus_error.
- HALT_OP, 5'b11010: opcode that halts the sequencer.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous active-high reset.
- run  in  1  level; fetching starts/continues only while high.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir  in  32  instruction register contents (IR[31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc).
- PCout, MARin, IncPC, Zlowin, Zhighin, ZLOout, ZHIout, PCin, read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath enables.
- Rout_en  out  1  a general register drives the bus.
- Rout_sel  out  4  index of the driving register.
- Rin_en  out  1  a general register loads from the bus.
- Rin_sel  out  4  index of the loading register.
- operation  out  5  ALU operation code.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- bus_error  out  1  sticky until clear; memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- States (encoding): IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- All outputs are Moore-decoded from registered state and ir, except MDRin, which depends on mem_ready.
- clear: state goes to IDLE on the next posedge. All enables, operation, illegal, and bus_error are 0. The wait counter is 0.
- clear wins over every other input, including mid-instruction; a partially executed instruction is abandoned with no further enables.
- IDLE: no enables asserted; goes to T0 when run=1.
- T0: PCout, MARin, IncPC, Zlowin asserted; then T1.
- T1: ZLOout, PCin, read asserted; MDRin = mem_ready.
  - PCin is asserted only in the first T1 cycle, so PC+1 is captured exactly once.
  - Stays in T1 while mem_ready=0, incrementing the wait counter.
  - mem_ready=1: go to T2 and reset the counter.
  - Counter reaching WAIT_LIMIT with mem_ready=0: set bus_error, go to HALT.
- T2: MDRout, IRin asserted; then T3.
- T3: decode ir[31:27].
  - opcode <= 5'b01100 (ALU R-type: operation=opcode): Rout_en, Rout_sel=rb, Yin; then T4.
  - HALT_OP: go to HALT with no enables.
  - Multiply/divide opcodes: see Optional Feature.
  - Any other opcode: illegal pulses for one cycle, no enables; go to T0 if run=1, else IDLE.
- T4: Rout_en, Rout_sel=rc, operation=opcode, Zlowin; for mul/div, Zhighin as well. Then T5.
- T5:
  - R-type: ZLOout, Rin_en, Rin_sel=ra.
  - mul/div: ZLOout, LOin; then T6.
  - After an R-type T5: go to T0 if run=1, else IDLE.
- T6 (mul/div only): ZHIout, HIin; next state chosen as after an R-type T5.
- run deasserting mid-instruction completes that instruction, then goes to IDLE.
- HALT: halted=1, no enables; exits only via clear.
- Never more than one bus driver (PCout, ZLOout, ZHIout, MDRout, Rout_en) in any cycle.
- operation holds its last value when not in T4; it is 0 after reset.
- Latency with mem_ready asserted in the first T1 cycle: R-type 6 cycles T0-T5; mul/div 7 cycles.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: opcodes 5'b01111 (mul) and 5'b10000 (div) run T3/T4/T5/T6 as above, with Zhighin in T4.
- Undefined: both opcodes are treated as illegal in T3. Zhighin, ZHIout, LOin, HIin are tied 0, and T6 is unreachable.

Test Plan:
- R6=0x12, R4=0x14, ir=0x53320000, run=1, mem_ready=1 in T1 → opcode 01010: T3 Rout_sel=6 + Yin; T4 Rout_sel=4, operation=01010, Zlowin; T5 Rin_sel=6 + ZLOout; back to T0 after 6 cycles.
- mem_ready held low 3 cycles in T1 → state_dbg=2 for 4 cycles, PCin high only in the first, MDRin only in the 4th, no bus_error.
- mem_ready held low → bus_error=1 after WAIT_LIMIT cycles; state HALT; halted=1 until clear.
- ir opcode 11111 → illegal is a single-cycle pulse at T3, no register/Y/Z enables; next state T0.
- clear asserted during T4 → next cycle state_dbg=0, all enables 0, operation=0; run=1 restarts at T0.
- ir opcode 01111 with ALU_SEQ_MULDIV_EN → T4 Zlowin+Zhighin, T5 ZLOout+LOin, T6 ZHIout+HIin. Without the macro → illegal pulse at T3.
